// File: rtl/instr_mem_fetch.sv
// Instruction memory with a registered fetch port, program-load write port and post-reset NOP clear.
// Define IMEM_WR_BYPASS_EN for write-first forwarding on a same-edge write/fetch to one index.
module instr_mem_fetch #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       PC_SHIFT  = 0,
  parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              stall,
  input  logic              mem_conflict,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_err,
  output logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int unsigned       CntW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0]   LastIdx   = CntW'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthExt  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   clr_cnt_q, clr_cnt_d;

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [CntW-1:0]   mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [ADDR_W-1:0] fetch_idx;
  logic              fetch_hit;
  logic              wr_hit;
  logic [CntW-1:0]   rd_idx;
  logic [DATA_W-1:0] fetch_word;

  assign fetch_idx = pc >> PC_SHIFT;
  assign fetch_hit = {1'b0, fetch_idx} < DepthExt;
  assign wr_hit    = {1'b0, wr_addr} < DepthExt;
  // Out-of-range indices never reach the array; they read entry 0 and the result is discarded.
  assign rd_idx    = fetch_hit ? fetch_idx[CntW-1:0] : '0;

`ifdef IMEM_WR_BYPASS_EN
  always_comb begin
    fetch_word = mem[rd_idx];
    if (state_q == StRun && wr_en && wr_hit && fetch_hit && (wr_addr == fetch_idx)) begin
      fetch_word = wr_data;
    end
  end
`else
  always_comb begin
    fetch_word = mem[rd_idx];
  end
`endif

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    pc_d      = pc_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = NOP_INSTR;

    case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        if (clr_cnt_q == LastIdx) begin
          state_d = StRun;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      StRun: begin
        mem_we    = wr_en & wr_hit;
        mem_waddr = wr_addr[CntW-1:0];
        mem_wdata = wr_data;

        if (stall) begin
          // Hold everything.
        end else if (mem_conflict) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end else if (fetch_req) begin
          valid_d = 1'b1;
          pc_d    = pc;
          if (fetch_hit) begin
            instr_d = fetch_word;
            err_d   = 1'b0;
          end else begin
            instr_d = NOP_INSTR;
            err_d   = 1'b1;
          end
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d   = StClear;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
    end
  end

  // Array has no reset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign instr_pc    = pc_q;
  assign fetch_err   = err_q;
  assign ready       = (state_q == StRun);

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Scoreboard bench for instr_mem_fetch (DEPTH=64, word-addressed PC).
// Follows IMEM_WR_BYPASS_EN for the same-edge write/fetch expectation.
module tb_instr_mem_fetch;

  localparam logic [15:0] Nop   = 16'h0800;
  localparam int          Depth = 64;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic        fetch_req;
  logic        stall;
  logic        mem_conflict;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic        fetch_err;
  logic        ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  instr_mem_fetch #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .DEPTH    (Depth),
    .PC_SHIFT (0),
    .NOP_INSTR(Nop)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .fetch_req   (fetch_req),
    .stall       (stall),
    .mem_conflict(mem_conflict),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .fetch_err   (fetch_err),
    .ready       (ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  typedef struct {
    logic [15:0] instr;
    logic        valid;
    logic [15:0] pc;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_mem [Depth];
  exp_t        model_out;
  int          n_checks = 0;
  int          n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < Depth; i++) model_mem[i] = Nop;
    model_out.instr = Nop;
    model_out.valid = 1'b0;
    model_out.pc    = '0;
    model_out.err   = 1'b0;
  endtask

  // Called just after a rising edge: drive, predict, clock, compare.
  task automatic step(input logic [15:0] p, input logic req, input logic stl, input logic conf,
                      input logic we, input logic [15:0] wa, input logic [15:0] wd);
    exp_t e;
    exp_t got;
    pc = p; fetch_req = req; stall = stl; mem_conflict = conf;
    wr_en = we; wr_addr = wa; wr_data = wd;
    e = model_out;
    if (stl) begin
      e = model_out;
    end else if (conf) begin
      e.instr = Nop; e.valid = 1'b0; e.err = 1'b0;
    end else if (req) begin
      e.valid = 1'b1; e.pc = p;
      if (p < Depth) begin
        e.instr = model_mem[p[5:0]];
`ifdef IMEM_WR_BYPASS_EN
        if (we && wa == p) e.instr = wd;
`endif
        e.err = 1'b0;
      end else begin
        e.instr = Nop; e.err = 1'b1;
      end
    end else begin
      e.instr = Nop; e.valid = 1'b0; e.err = 1'b0;
    end
    if (we && wa < Depth) model_mem[wa[5:0]] = wd;
    model_out = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("instr", 32'(instr), 32'(got.instr));
    check("instr_valid", 32'(instr_valid), 32'(got.valid));
    check("instr_pc", 32'(instr_pc), 32'(got.pc));
    check("fetch_err", 32'(fetch_err), 32'(got.err));
    check("ready_run", 32'(ready), 32'd1);
  endtask

  task automatic fetch(input logic [15:0] p);
    step(p, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic write(input logic [15:0] a, input logic [15:0] d);
    step(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  // Called with rst high just released at a falling edge; counts edges until ready.
  task automatic wait_ready(input string tag);
    int k;
    logic bad_valid;
    k = 0;
    bad_valid = 1'b0;
    while (k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (instr_valid) bad_valid = 1'b1;
      if (ready) break;
    end
    check(tag, 32'(k), 32'(Depth));
    check({tag, "_valid"}, 32'(bad_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, 32'(instr), 32'(Nop));
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_pc"}, 32'(instr_pc), 32'd0);
    check({tag, "_err"}, 32'(fetch_err), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
  endtask

  initial begin
    rst = 1'b0; pc = '0; fetch_req = 1'b0; stall = 1'b0; mem_conflict = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    // Fetch and write requests during clear must be ignored.
    fetch_req = 1'b1; pc = 16'd5; wr_en = 1'b1; wr_addr = 16'd5; wr_data = 16'hDEAD;
    @(negedge clk);
    rst = 1'b1;
    wait_ready("clear_len");

    for (int i = 0; i < Depth; i++) fetch(16'(i));

    write(16'd5, 16'h4907);
    fetch(16'd5);

    write(16'd2, 16'h1003);
    write(16'd3, 16'h4F01);
    fetch(16'd2);
    repeat (3) step(16'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    step(16'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    fetch(16'd3);
    // stall with a conflict and a write: write lands, outputs hold
    step(16'd9, 1'b1, 1'b1, 1'b1, 1'b1, 16'd9, 16'h7A7A);
    fetch(16'd9);

    fetch(16'd64);
    write(16'd64, 16'hABCD);
    fetch(16'd0);
    fetch(16'hFFFF);
    step(16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    step(16'd7, 1'b1, 1'b0, 1'b0, 1'b1, 16'd7, 16'hE1E7);
    fetch(16'd7);

    for (int i = 0; i < 60; i++) begin
      step(16'($urandom_range(0, 70)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 2) == 0), 16'($urandom_range(0, 70)), 16'($urandom));
    end
    fetch(16'd7);

    // Asynchronous reset mid-cycle while outputs carry a valid fetch.
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_midclear");
    @(negedge clk);
    rst = 1'b1;
    wait_ready("reclear_len");
    fetch(16'd5);
    fetch(16'd7);
    fetch(16'd63);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, expected completion");
    $fatal(1, "timeout");
  end

endmodule
